// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory block.
// Optional build macro: DMEM_STATS_EN (completion counters on the top).
package dmem_pkg;

    localparam int unsigned OFFSET_W        = 4;
    localparam int unsigned BLOCK_W_DEFAULT = 128;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned STAT_W          = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } dmem_state_e;

    // Strip the in-block byte offset; the caller truncates to its index width.
    function automatic logic [ADDR_W-1:0] blk_index(input logic [ADDR_W-1:0] addr);
        return addr >> OFFSET_W;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Block-transfer handshake between the cache controller and main data memory.
interface dmem_if #(
    parameter int unsigned BLOCK_W = dmem_pkg::BLOCK_W_DEFAULT
);

    logic               mem_Read;
    logic               mem_Write;
    logic [31:0]        mem_Address;
    logic [BLOCK_W-1:0] mem_Writedata;
    logic [BLOCK_W-1:0] mem_Readdata;
    logic               mem_BusyWait;

    modport master (
        output mem_Read, mem_Write, mem_Address, mem_Writedata,
        input  mem_Readdata, mem_BusyWait
    );

    modport slave (
        input  mem_Read, mem_Write, mem_Address, mem_Writedata,
        output mem_Readdata, mem_BusyWait
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous block array with registered read data; contents survive reset.
module dmem_array #(
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned IDX_W   = 8
) (
    input  logic               clock,
    input  logic               we,
    input  logic [IDX_W-1:0]   idx,
    input  logic [BLOCK_W-1:0] wdata,
    output logic [BLOCK_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [BLOCK_W-1:0] mem [0:DEPTH-1];

    // Write when enabled; read the addressed block every cycle.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/data_memory_block.sv
// Main data memory: whole-block reads/writes with a fixed multi-cycle latency.
// Optional build macro: DMEM_STATS_EN adds rd_count/wr_count completion counters.
module data_memory_block
    import dmem_pkg::*;
#(
    parameter int unsigned BLOCK_W = dmem_pkg::BLOCK_W_DEFAULT,
    parameter int unsigned IDX_W   = 8,
    parameter int unsigned LATENCY = 5
) (
    input  logic          clock,
    input  logic          reset,
    dmem_if.slave         bus
`ifdef DMEM_STATS_EN
    ,
    output logic [STAT_W-1:0] rd_count,
    output logic [STAT_W-1:0] wr_count
`endif
);

    dmem_state_e        state_q;
    dmem_state_e        state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               op_wr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BLOCK_W-1:0] wdata_q;

    logic               req;
    logic               accept;
    logic               finish;
    logic [IDX_W-1:0]   addr_idx;
    logic [IDX_W-1:0]   arr_idx;
    logic               arr_we;
    logic [BLOCK_W-1:0] arr_rdata;

    assign req      = bus.mem_Read | bus.mem_Write;
    assign accept   = (state_q == IDLE) & req;
    assign finish   = (state_q == ACCESS) & (cnt_q == '0);
    assign addr_idx = IDX_W'(blk_index(bus.mem_Address));

    // Busy from the first request cycle through ACCESS; forced low under reset.
    assign bus.mem_BusyWait = reset & (accept | (state_q == ACCESS));

    // State and latency counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture op, index and data on accept so later input changes are ignored.
    always_ff @(posedge clock) begin
        if (accept) begin
            op_wr_q <= bus.mem_Write;
            idx_q   <= addr_idx;
            wdata_q <= bus.mem_Writedata;
        end
    end

    // The array is pre-read one edge ahead, so steer it with the live index while idle.
    assign arr_idx = (state_q == IDLE) ? addr_idx : idx_q;
    assign arr_we  = finish & op_wr_q;

    dmem_array #(
        .BLOCK_W (BLOCK_W),
        .IDX_W   (IDX_W)
    ) u_array (
        .clock (clock),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // Read data register, updated only when a read completes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.mem_Readdata <= '0;
        end else if (finish && !op_wr_q) begin
            bus.mem_Readdata <= arr_rdata;
        end
    end

`ifdef DMEM_STATS_EN
    // Saturating completion counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (finish) begin
            if (op_wr_q) begin
                if (wr_count != '1) begin
                    wr_count <= wr_count + STAT_W'(1);
                end
            end else begin
                if (rd_count != '1) begin
                    rd_count <= rd_count + STAT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_block.sv
// Directed bench for data_memory_block: LATENCY=5 and LATENCY=1 instances.
module tb_data_memory_block;

    localparam logic [127:0] A5 = {16{8'hA5}};
    localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] DX = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] D2 = 128'h5A5A_0F0F_1234_8765_CAFE_F00D_BEEF_0001;
    localparam logic [127:0] DK = 128'h7777_0000_7777_0000_7777_0000_7777_0007;
    localparam logic [127:0] DZ = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
    localparam logic [127:0] DE = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    dmem_if #(.BLOCK_W(128)) b5 ();
    dmem_if #(.BLOCK_W(128)) b1 ();

`ifdef DMEM_STATS_EN
    logic [31:0] rd5, wr5, rd1, wr1;
`endif

    data_memory_block #(.BLOCK_W(128), .IDX_W(8), .LATENCY(5)) dut5 (
        .clock (clock),
        .reset (reset),
        .bus   (b5)
`ifdef DMEM_STATS_EN
        ,
        .rd_count (rd5),
        .wr_count (wr5)
`endif
    );

    data_memory_block #(.BLOCK_W(128), .IDX_W(8), .LATENCY(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (b1)
`ifdef DMEM_STATS_EN
        ,
        .rd_count (rd1),
        .wr_count (wr1)
`endif
    );

    typedef struct {
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit sel, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [127:0] d);
        if (sel) begin
            b1.mem_Read = rd; b1.mem_Write = wr; b1.mem_Address = a; b1.mem_Writedata = d;
        end else begin
            b5.mem_Read = rd; b5.mem_Write = wr; b5.mem_Address = a; b5.mem_Writedata = d;
        end
    endtask

    function automatic logic get_busy(input bit sel);
        return sel ? b1.mem_BusyWait : b5.mem_BusyWait;
    endfunction

    function automatic logic [127:0] get_rdata(input bit sel);
        return sel ? b1.mem_Readdata : b5.mem_Readdata;
    endfunction

    // Present a request, count busy cycles at negedges, drop it once busy falls.
    task automatic txn(input bit sel, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [127:0] d, output int cyc);
        @(posedge clock); #1;
        set_req(sel, rd, wr, a, d);
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clock);
            if (!get_busy(sel)) break;
            cyc++;
            @(posedge clock); #1;
        end
        check("txn_timeout", 128'(cyc >= 100), 128'd0);
        set_req(sel, 1'b0, 1'b0, a, '0);
    endtask

    initial begin
        int cyc;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0F20, D1, A5};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0F2C, '0, D1};
        vecs[2] = '{1'b1, 1'b1, 32'h1000_0040, DX, D1};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0040, '0, DX};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0F20, '0, D1};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0FF0, D2, D1};
        vecs[6] = '{1'b1, 1'b0, 32'hABCD_EFF8, '0, D2};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0030, '0, A5};

        set_req(1'b0, 1'b1, 1'b0, 32'h30, '0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, '0);
        #3 reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_busy_gated", 128'(b5.mem_BusyWait), 128'd0);
        check("reset_rdata", b5.mem_Readdata, 128'd0);
        check("reset_rdata_l1", b1.mem_Readdata, 128'd0);
        set_req(1'b0, 1'b0, 1'b0, 32'h30, '0);
        reset = 1'b1;
        @(negedge clock);
        check("idle_busy", 128'(b5.mem_BusyWait), 128'd0);

        // Preload index 3, reset, then read it back.
        txn(1'b0, 1'b0, 1'b1, 32'h30, A5, cyc);
        check("preload_busy", 128'(cyc), 128'd6);
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        txn(1'b0, 1'b1, 1'b0, 32'h30, '0, cyc);
        check("read_after_reset_busy", 128'(cyc), 128'd6);
        check("read_after_reset_data", b5.mem_Readdata, A5);

        for (int i = 0; i < 8; i++) begin
            txn(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, cyc);
            check($sformatf("vec%0d_busy", i), 128'(cyc), 128'd6);
            check($sformatf("vec%0d_rdata", i), b5.mem_Readdata, vecs[i].exp_rdata);
        end

        // Address change and request drop mid-ACCESS must not disturb the latched read.
        @(posedge clock); #1;
        set_req(1'b0, 1'b1, 1'b0, 32'h0F20, '0);
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clock);
            if (!b5.mem_BusyWait) break;
            cyc++;
            @(posedge clock); #1;
            if (cyc == 2) set_req(1'b0, 1'b0, 1'b0, 32'h40, '0);
        end
        check("midacc_busy", 128'(cyc), 128'd6);
        check("midacc_rdata", b5.mem_Readdata, D1);

        // Reset during cycle 3 of a write aborts it.
        txn(1'b0, 1'b0, 1'b1, 32'h70, DK, cyc);
        @(posedge clock); #1;
        set_req(1'b0, 1'b0, 1'b1, 32'h70, DZ);
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("abort_busy_low", 128'(b5.mem_BusyWait), 128'd0);
        set_req(1'b0, 1'b0, 1'b0, 32'h70, '0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("abort_idle_busy", 128'(b5.mem_BusyWait), 128'd0);
        check("abort_rdata_cleared", b5.mem_Readdata, 128'd0);
        txn(1'b0, 1'b1, 1'b0, 32'h70, '0, cyc);
        check("abort_read_busy", 128'(cyc), 128'd6);
        check("abort_array_kept", b5.mem_Readdata, DK);

        // LATENCY=1 instance.
        txn(1'b1, 1'b0, 1'b1, 32'h20, DE, cyc);
        check("l1_write_busy", 128'(cyc), 128'd2);
        txn(1'b1, 1'b1, 1'b0, 32'h24, '0, cyc);
        check("l1_read_busy", 128'(cyc), 128'd2);
        check("l1_read_data", b1.mem_Readdata, DE);
        txn(1'b1, 1'b0, 1'b1, 32'h70, DK, cyc);
        @(posedge clock); #1;
        set_req(1'b1, 1'b0, 1'b1, 32'h70, DZ);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("l1_abort_busy_low", 128'(b1.mem_BusyWait), 128'd0);
        set_req(1'b1, 1'b0, 1'b0, 32'h70, '0);
        @(posedge clock); #1;
        reset = 1'b1;
        txn(1'b1, 1'b1, 1'b0, 32'h70, '0, cyc);
        check("l1_abort_read_busy", 128'(cyc), 128'd2);
        check("l1_abort_array_kept", b1.mem_Readdata, DK);

`ifdef DMEM_STATS_EN
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        check("stats_rd_zero", 128'(rd5), 128'd0);
        check("stats_wr_zero", 128'(wr5), 128'd0);
        txn(1'b0, 1'b1, 1'b0, 32'h30, '0, cyc);
        txn(1'b0, 1'b0, 1'b1, 32'h80, DE, cyc);
        txn(1'b0, 1'b1, 1'b0, 32'h80, '0, cyc);
        txn(1'b0, 1'b1, 1'b1, 32'h90, D2, cyc);
        txn(1'b0, 1'b1, 1'b0, 32'h90, '0, cyc);
        @(negedge clock);
        check("stats_rd", 128'(rd5), 128'd3);
        check("stats_wr", 128'(wr5), 128'd2);
        @(posedge clock); #1 reset = 1'b0;
        #1;
        check("stats_rd_reset", 128'(rd5), 128'd0);
        check("stats_wr_reset", 128'(wr5), 128'd0);
        reset = 1'b1;
`endif

        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
